// File: rtl/adpcm_tdm_tx_if.sv
// Code-word handshake between the ADPCM encoder datapath (master) and the TDM transmitter (slave).
// in_slot tells the producer which TDM slot a code accepted this cycle will occupy.
interface adpcm_tdm_tx_if #(
    parameter int unsigned CODE_W  = 4,
    parameter int unsigned SLOT_IW = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [CODE_W-1:0]  in_code;
    logic [SLOT_IW-1:0] in_slot;

    modport master (
        output in_valid,
        output in_code,
        input  in_ready,
        input  in_slot
    );

    modport slave (
        input  in_valid,
        input  in_code,
        output in_ready,
        output in_slot
    );
endinterface

// File: rtl/adpcm_tdm_tx.sv
// ADPCM serial TDM transmitter: one held code per slot, shifted MSB-first with frame sync.
// Optional MCAC_TX_PARITY_EN puts the even parity of the sent code in each slot LSB.
module adpcm_tdm_tx #(
    parameter int unsigned       CODE_W    = 4,
    parameter int unsigned       SLOT_W    = 8,
    parameter int unsigned       NCH       = 32,
    parameter logic [CODE_W-1:0] IDLE_CODE = '1,
    localparam int unsigned      SLOT_IW   = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned      BIT_IW    = $clog2(SLOT_W)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic                 bit_en,
    adpcm_tdm_tx_if.slave        in_if,
    output logic                 sdo,
    output logic                 fs,
    output logic                 underrun
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e              state_q, state_d;
    logic [BIT_IW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SLOT_IW-1:0]  slot_cnt_q, slot_cnt_d;
    logic [SLOT_W-1:0]   shift_q, shift_d;
    logic [CODE_W-1:0]   hold_q, hold_d;
    logic                hold_valid_q, hold_valid_d;
    logic                sdo_q, sdo_d;
    logic                fs_q, fs_d;
    logic                underrun_q, underrun_d;

    logic                load_cycle;
    logic                frame_end;
    logic                accept;
    logic [CODE_W-1:0]   tx_code;
    logic [SLOT_W-1:0]   word;

    assign load_cycle = bit_en && (bit_cnt_q == '0) && ((state_q == StRun) || en);
    // Frame ends on the last bit of the last slot; en only matters here, never mid-frame.
    assign frame_end  = bit_en && (state_q == StRun) && (bit_cnt_q == BIT_IW'(SLOT_W - 1)) &&
                        (slot_cnt_q == '0) && !en;
    assign accept     = in_if.in_valid && in_if.in_ready;
    assign tx_code    = hold_valid_q ? hold_q : IDLE_CODE;

    always_comb begin
        word = '0;
        word[SLOT_W-1 -: CODE_W] = tx_code;
`ifdef MCAC_TX_PARITY_EN
        word[0] = ^tx_code;
`else
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (load_cycle) state_d = StRun;
            StRun:   if (frame_end)  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output and datapath next-state logic
    always_comb begin
        in_if.in_ready = !hold_valid_q && !load_cycle;
        bit_cnt_d      = bit_cnt_q;
        slot_cnt_d     = slot_cnt_q;
        shift_d        = shift_q;
        hold_d         = hold_q;
        hold_valid_d   = hold_valid_q;
        sdo_d          = sdo_q;
        fs_d           = fs_q;
        underrun_d     = 1'b0;

        if (accept) begin
            hold_d       = in_if.in_code;
            hold_valid_d = 1'b1;
        end

        if (load_cycle) begin
            sdo_d        = word[SLOT_W-1];
            shift_d      = word << 1;
            fs_d         = (slot_cnt_q == '0);
            hold_valid_d = 1'b0;
            underrun_d   = !hold_valid_q;
            slot_cnt_d   = (slot_cnt_q == SLOT_IW'(NCH - 1)) ? '0 : slot_cnt_q + 1'b1;
        end else if (bit_en && (state_q == StRun)) begin
            sdo_d   = frame_end ? 1'b0 : shift_q[SLOT_W-1];
            shift_d = shift_q << 1;
            fs_d    = 1'b0;
        end

        if (bit_en && ((state_q == StRun) || load_cycle)) begin
            bit_cnt_d = (bit_cnt_q == BIT_IW'(SLOT_W - 1)) ? '0 : bit_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q    <= '0;
            slot_cnt_q   <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            sdo_q        <= 1'b0;
            fs_q         <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            bit_cnt_q    <= bit_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            sdo_q        <= sdo_d;
            fs_q         <= fs_d;
            underrun_q   <= underrun_d;
        end
    end

    assign in_if.in_slot = slot_cnt_q;
    assign sdo           = sdo_q;
    assign fs            = fs_q;
    assign underrun      = underrun_q;

endmodule

// File: doc/adpcm_tdm_tx.md
Name: adpcm_tdm_tx

Overview:
- Transmit end of the multi-channel ADPCM serial TDM link; the TDM receive deserializer is the peer block.
- Accepts one G.726 code word at a time from the encoder datapath over a valid/ready handshake.
- Holds each code for its channel slot and shifts it out MSB-first on a single serial line with a frame sync.
- Frames are NCH slots of SLOT_W bits; bit timing comes from a one-cycle bit strobe.

Parameters:
- CODE_W, 4: ADPCM code width in bits (2..5 covers all G.726 rates).
- SLOT_W, 8: bits per TDM slot; must be greater than CODE_W. Code is sent in the slot MSBs, remaining bits zero.
- NCH, 32: channels (slots) per frame.
- IDLE_CODE, all-ones of CODE_W: code sent in a slot when no data is held.

Ports:
- clk, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- en, input, 1: transmit enable.
- bit_en, input, 1: serial bit strobe, one clk cycle wide per serial bit.
- in_valid, input, 1: in_code is valid.
- in_ready, output, 1: block can accept in_code this cycle.
- in_code, input, CODE_W: ADPCM code word.
- in_slot, output, clog2(NCH): slot in which a code accepted now will be transmitted.
- sdo, output, 1: serial data out.
- fs, output, 1: frame sync, high for the first bit period of slot 0.
- underrun, output, 1: one-clk pulse when IDLE_CODE is substituted for missing data.

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous, active-low; the clock and reset polarity/synchronicity are fixed.
- Reset values:
  - state = IDLE; bit_cnt, slot_cnt, shift register = 0; hold_valid = 0.
  - sdo = 0, fs = 0, underrun = 0. in_ready = 1 once reset_n is high.
- Reset mid-frame: aborts immediately; the held code is discarded; no partial slot is resumed.
- FSM, two states:
  - IDLE: sdo = 0, fs = 0.
  - RUN.
- Load cycle: bit_en && bit_cnt==0 && (state==RUN || en).
  - IDLE to RUN happens on a load cycle.
  - RUN to IDLE happens on bit_en with bit_cnt==SLOT_W-1 && slot_cnt==0 && !en, i.e. the frame completes. That same edge registers sdo <= 0.
  - Dropping en mid-frame never truncates the frame.
- In a load cycle:
  - word = hold_valid ? {hold, zeros} : {IDLE_CODE, zeros}.
  - sdo <= word MSB; shift register <= word << 1.
  - fs <= (slot_cnt==0).
  - hold_valid <= 0.
  - underrun pulses 1 clk if !hold_valid.
  - slot_cnt increments, wrapping NCH-1 to 0.
- Other bit_en cycles in RUN: sdo <= shift MSB, shift <<= 1, fs <= 0.
- Counters:
  - bit_cnt increments on every RUN bit_en, wrapping SLOT_W-1 to 0.
  - slot_cnt is the next slot to be loaded.
  - All outputs are registered and change only on bit_en cycles.
- Handshake:
  - in_ready = !hold_valid && !load_cycle (combinational).
  - in_valid && in_ready loads hold and sets hold_valid.
  - in_slot = slot_cnt.
  - Preloading in IDLE is allowed; that code goes to slot 0.
- Latency: a code accepted before a slot's load cycle appears on sdo on the clk edge of that load cycle. Its bits follow on the next CODE_W-1 bit_en edges.
- bit_en held high continuously gives 1 bit per clk, which is legal.

Optional Feature:
- Macro: MCAC_TX_PARITY_EN.
  - Defined: the slot LSB carries the even parity of the transmitted code, including IDLE_CODE. Requires SLOT_W >= CODE_W+1.
  - Undefined: all pad bits are zero.

Test Plan:
- Test 1 (NCH=4, SLOT_W=8, CODE_W=4, bit_en every 2nd clk): en=1, codes 4'hA,4'h3,4'h0,4'hF supplied in order.
  - sdo = 10100000 00110000 00000000 11110000.
  - fs high only during bit 0 of slot 0.
  - underrun never pulses.
- Test 2: no codes supplied for slot 2.
  - Slot 2 carries 11110000.
  - underrun pulses exactly once, on the slot 2 load cycle.
  - in_slot reads 3 afterwards.
- Test 3: in_valid asserted on a load cycle with hold empty.
  - in_ready = 0 that cycle.
  - Code accepted next cycle and sent in the following slot.
- Test 4: en dropped during slot 1.
  - Slots 1..3 still sent.
  - After the last bit of slot 3: state IDLE, sdo = 0, no fs.
- Test 5: reset_n pulsed low mid-slot 2.
  - sdo, fs, underrun = 0 immediately without a clk edge.
  - Re-enable restarts at slot 0 with fs.
- Test 6: MCAC_TX_PARITY_EN defined, code 4'hB.
  - Slot = 10110001.
  - Code 4'h3 gives slot 00110000.
